// File: rtl/pu_add_cmp_pipe.sv
`timescale 1ns/1ps
// pu_add_cmp_pipe: two-stage pipelined add/sub/compare processing unit.
//   S1 holds an accepted operation with its sampled operands.
//   S2 holds the computed result until writeback accepts it.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     operation handshake from the Control Unit
//   i_opcode, i_rega/b/d  operation, source and destination register numbers
//   i_use_imm, i_imm      when set, operand B is the sign-extended immediate
//   i_cmp_op              compare selector used by ICMP
//   i_unique_ack          an upstream unit already claims the operation
//   o_unique_ack          this unit claims the operation (combinational)
//   o_sela / o_selb       register-file read selects (pass-through)
//   ina / inb             register-file read data
//   write_reg/data/en     register writeback
//   flag_cmp, write_flag  compare-flag writeback
//   o_carry, o_overflow   architectural carry / signed-overflow flags
//   i_wb_ready            writeback accepts the retiring operation
// Optional feature macro: PU_ADD_CMP_SAT_EN adds ADDS (6) / SUBS (7)
// signed saturating add/sub.
module pu_add_cmp_pipe #(
    parameter int unsigned OPTION_REG_WIDTH    = 64,
    parameter int unsigned OPTION_OPCODE_WIDTH = 6,
    parameter int unsigned OPTION_IMM_WIDTH    = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [OPTION_OPCODE_WIDTH-1:0] i_opcode,
    input  logic [4:0]                     i_rega,
    input  logic [4:0]                     i_regb,
    input  logic [4:0]                     i_regd,
    input  logic                           i_use_imm,
    input  logic [OPTION_IMM_WIDTH-1:0]    i_imm,
    input  logic [3:0]                     i_cmp_op,
    input  logic                           i_unique_ack,
    output logic                           o_unique_ack,
    output logic [4:0]                     o_sela,
    output logic [4:0]                     o_selb,
    input  logic [OPTION_REG_WIDTH-1:0]    ina,
    input  logic [OPTION_REG_WIDTH-1:0]    inb,
    output logic [4:0]                     write_reg,
    output logic [OPTION_REG_WIDTH-1:0]    write_data,
    output logic                           write_en,
    output logic                           flag_cmp,
    output logic                           write_flag,
    output logic                           o_carry,
    output logic                           o_overflow,
    input  logic                           i_wb_ready
);

    localparam int unsigned W  = OPTION_REG_WIDTH;
    localparam int unsigned W1 = W + 1;
    localparam int unsigned OW = OPTION_OPCODE_WIDTH;

    localparam logic [OW-1:0] OP_SUB  = OW'(1);
    localparam logic [OW-1:0] OP_ADD  = OW'(2);
    localparam logic [OW-1:0] OP_ICMP = OW'(3);
    localparam logic [OW-1:0] OP_ADDC = OW'(4);
    localparam logic [OW-1:0] OP_SUBC = OW'(5);
`ifdef PU_ADD_CMP_SAT_EN
    localparam logic [OW-1:0] OP_ADDS = OW'(6);
    localparam logic [OW-1:0] OP_SUBS = OW'(7);
`endif

    localparam logic [3:0] CMP_NEQ = 4'd1;
    localparam logic [3:0] CMP_GTU = 4'd2;
    localparam logic [3:0] CMP_GTS = 4'd3;
    localparam logic [3:0] CMP_GEU = 4'd4;
    localparam logic [3:0] CMP_GES = 4'd5;
    localparam logic [3:0] CMP_LTU = 4'd6;
    localparam logic [3:0] CMP_LTS = 4'd7;
    localparam logic [3:0] CMP_LEU = 4'd8;
    localparam logic [3:0] CMP_LES = 4'd9;
    localparam logic [3:0] CMP_EQ  = 4'd10;

    // Stage 1: accepted operation and sampled operands
    logic          s1_valid_q, s1_valid_d;
    logic [OW-1:0] s1_op_q,    s1_op_d;
    logic [4:0]    s1_regd_q,  s1_regd_d;
    logic [3:0]    s1_cmp_q,   s1_cmp_d;
    logic [W-1:0]  s1_a_q,     s1_a_d;
    logic [W-1:0]  s1_b_q,     s1_b_d;

    // Stage 2: retiring result; valid is wen | wflag
    logic          s2_wen_q,   s2_wen_d;
    logic          s2_wflag_q, s2_wflag_d;
    logic [4:0]    s2_reg_q,   s2_reg_d;
    logic [W-1:0]  s2_data_q,  s2_data_d;
    logic          s2_flag_q,  s2_flag_d;
    logic          carry_q,    carry_d;
    logic          ovf_q,      ovf_d;

    logic          match_c;
    logic          s2_adv_c;
    logic          s1_adv_c;
    logic          accept_c;
    logic [W-1:0]  imm_ext_c;
    logic          b_inv_c;
    logic          cin_c;
    logic [W-1:0]  b_eff_c;
    logic [W-1:0]  sum_c;
    logic          cout_c;
    logic          ovf_c;
    logic          ltu_c;
    logic          lts_c;
    logic          eq_c;
    logic          cmp_c;
    logic [W-1:0]  res_c;

    // Opcode recognition
    always_comb begin
        match_c = 1'b0;
        case (i_opcode)
            OP_SUB, OP_ADD, OP_ICMP, OP_ADDC, OP_SUBC: match_c = 1'b1;
`ifdef PU_ADD_CMP_SAT_EN
            OP_ADDS, OP_SUBS:                          match_c = 1'b1;
`endif
            default:                                   match_c = 1'b0;
        endcase
    end

    assign o_unique_ack = match_c & ~i_unique_ack;
    assign o_sela       = i_rega;
    assign o_selb       = i_regb;

    // Flow control: each stage advances when it is empty or drains
    assign s2_adv_c = ~(s2_wen_q | s2_wflag_q) | i_wb_ready;
    assign s1_adv_c = ~s1_valid_q | s2_adv_c;
    assign o_ready  = s1_adv_c;
    assign accept_c = i_valid & s1_adv_c & o_unique_ack;
    assign imm_ext_c = W'($signed(i_imm));

    // Stage-2 arithmetic: single adder computes A + B' + cin
    always_comb begin
        b_inv_c = 1'b0;
        cin_c   = 1'b0;
        case (s1_op_q)
            OP_SUB, OP_ICMP: begin
                b_inv_c = 1'b1;
                cin_c   = 1'b1;
            end
            OP_ADDC: cin_c = carry_q;
            OP_SUBC: begin
                b_inv_c = 1'b1;
                cin_c   = carry_q;
            end
`ifdef PU_ADD_CMP_SAT_EN
            OP_SUBS: begin
                b_inv_c = 1'b1;
                cin_c   = 1'b1;
            end
`endif
            default: ;
        endcase
        b_eff_c          = b_inv_c ? ~s1_b_q : s1_b_q;
        {cout_c, sum_c}  = W1'(s1_a_q) + W1'(b_eff_c) + W1'(cin_c);
        ovf_c            = (s1_a_q[W-1] == b_eff_c[W-1]) & (s1_a_q[W-1] ^ sum_c[W-1]);
        ltu_c            = ~cout_c;
        lts_c            = sum_c[W-1] ^ ovf_c;
        eq_c             = (s1_a_q == s1_b_q);

        res_c = sum_c;
`ifdef PU_ADD_CMP_SAT_EN
        // Clamp toward the sign of A on signed overflow
        if (((s1_op_q == OP_ADDS) || (s1_op_q == OP_SUBS)) && ovf_c) begin
            res_c = s1_a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif

        case (s1_cmp_q)
            CMP_EQ:  cmp_c = eq_c;
            CMP_NEQ: cmp_c = ~eq_c;
            CMP_GTU: cmp_c = ~ltu_c & ~eq_c;
            CMP_GTS: cmp_c = ~lts_c & ~eq_c;
            CMP_GEU: cmp_c = ~ltu_c;
            CMP_GES: cmp_c = ~lts_c;
            CMP_LTU: cmp_c = ltu_c;
            CMP_LTS: cmp_c = lts_c;
            CMP_LEU: cmp_c = ltu_c | eq_c;
            CMP_LES: cmp_c = lts_c | eq_c;
            default: cmp_c = 1'b0;
        endcase
    end

    // Next-state for both pipeline stages and the architectural flags
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_regd_d  = s1_regd_q;
        s1_cmp_d   = s1_cmp_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_wen_d   = s2_wen_q;
        s2_wflag_d = s2_wflag_q;
        s2_reg_d   = s2_reg_q;
        s2_data_d  = s2_data_q;
        s2_flag_d  = s2_flag_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;

        if (s1_adv_c) begin
            s1_valid_d = accept_c;
            if (accept_c) begin
                s1_op_d   = i_opcode;
                s1_regd_d = i_regd;
                s1_cmp_d  = i_cmp_op;
                s1_a_d    = ina;
                s1_b_d    = i_use_imm ? imm_ext_c : inb;
            end
        end

        if (s2_adv_c) begin
            s2_wen_d   = s1_valid_q & (s1_op_q != OP_ICMP);
            s2_wflag_d = s1_valid_q & (s1_op_q == OP_ICMP);
            if (s1_valid_q) begin
                s2_reg_d  = s1_regd_q;
                s2_data_d = res_c;
                s2_flag_d = cmp_c;
                // ICMP leaves the architectural flags untouched
                if (s1_op_q != OP_ICMP) begin
                    carry_d = cout_c;
                    ovf_d   = ovf_c;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_regd_q  <= '0;
            s1_cmp_q   <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_wen_q   <= 1'b0;
            s2_wflag_q <= 1'b0;
            s2_reg_q   <= '0;
            s2_data_q  <= '0;
            s2_flag_q  <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_regd_q  <= s1_regd_d;
            s1_cmp_q   <= s1_cmp_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_wen_q   <= s2_wen_d;
            s2_wflag_q <= s2_wflag_d;
            s2_reg_q   <= s2_reg_d;
            s2_data_q  <= s2_data_d;
            s2_flag_q  <= s2_flag_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
        end
    end

    assign write_en   = s2_wen_q;
    assign write_flag = s2_wflag_q;
    assign write_reg  = s2_reg_q;
    assign write_data = s2_data_q;
    assign flag_cmp   = s2_flag_q;
    assign o_carry    = carry_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_pu_add_cmp_pipe.sv
`timescale 1ns/1ps
// Bench for pu_add_cmp_pipe: directed vectors, an in-order expectation
// queue built from plain signed/unsigned arithmetic, and literal pins.
module tb_pu_add_cmp_pipe;

    localparam int unsigned W  = 64;
    localparam int unsigned WX = W + 2;

    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_ADD  = 6'd2;
    localparam logic [5:0] OP_ICMP = 6'd3;
    localparam logic [5:0] OP_ADDC = 6'd4;
    localparam logic [5:0] OP_SUBC = 6'd5;
    localparam logic [5:0] OP_ADDS = 6'd6;
    localparam logic [5:0] OP_SUBS = 6'd7;

    localparam logic signed [W+1:0] ZERO  = '0;
    localparam logic signed [W+1:0] ONE   = WX'(1);
    localparam logic signed [W+1:0] TWO_W = {2'b01, {W{1'b0}}};
    localparam logic signed [W+1:0] SMAX  = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SMIN  = {3'b111, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAXP   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINN   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL1   = {W{1'b1}};

    typedef struct packed {
        logic         wen;
        logic         wflag;
        logic [4:0]   rd;
        logic [W-1:0] data;
        logic         flag;
        logic         carry;
        logic         ovf;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [5:0]    i_opcode;
    logic [4:0]    i_rega, i_regb, i_regd;
    logic          i_use_imm;
    logic [15:0]   i_imm;
    logic [3:0]    i_cmp_op;
    logic          i_unique_ack;
    logic          o_unique_ack;
    logic [4:0]    o_sela, o_selb;
    logic [W-1:0]  ina, inb;
    logic [4:0]    write_reg;
    logic [W-1:0]  write_data;
    logic          write_en, flag_cmp, write_flag;
    logic          o_carry, o_overflow;
    logic          i_wb_ready;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    exp_t ce;
    logic m_carry = 1'b0;
    logic m_ovf   = 1'b0;

    pu_add_cmp_pipe dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_opcode     (i_opcode),
        .i_rega       (i_rega),
        .i_regb       (i_regb),
        .i_regd       (i_regd),
        .i_use_imm    (i_use_imm),
        .i_imm        (i_imm),
        .i_cmp_op     (i_cmp_op),
        .i_unique_ack (i_unique_ack),
        .o_unique_ack (o_unique_ack),
        .o_sela       (o_sela),
        .o_selb       (o_selb),
        .ina          (ina),
        .inb          (inb),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .write_en     (write_en),
        .flag_cmp     (flag_cmp),
        .write_flag   (write_flag),
        .o_carry      (o_carry),
        .o_overflow   (o_overflow),
        .i_wb_ready   (i_wb_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b, want %0b", name, act, exp);
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Expected outcome of one accepted operation, in program order
    function automatic void model_push(input logic [5:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [3:0] cmp,
                                       input logic [4:0] rd);
        exp_t e;
        logic signed [W+1:0] ua, ub, sa, sb, cc, uw, sw;
        logic is_sub;
        ua = $signed({2'b00, a});
        ub = $signed({2'b00, b});
        sa = $signed({{2{a[W-1]}}, a});
        sb = $signed({{2{b[W-1]}}, b});
        cc = m_carry ? ONE : ZERO;
        e  = '0;
        e.rd    = rd;
        e.carry = m_carry;
        e.ovf   = m_ovf;
        if (op == OP_ICMP) begin
            e.wflag = 1'b1;
            case (cmp)
                4'd10:   e.flag = (a == b);
                4'd1:    e.flag = (a != b);
                4'd2:    e.flag = (a > b);
                4'd3:    e.flag = ($signed(a) > $signed(b));
                4'd4:    e.flag = (a >= b);
                4'd5:    e.flag = ($signed(a) >= $signed(b));
                4'd6:    e.flag = (a < b);
                4'd7:    e.flag = ($signed(a) < $signed(b));
                4'd8:    e.flag = (a <= b);
                4'd9:    e.flag = ($signed(a) <= $signed(b));
                default: e.flag = 1'b0;
            endcase
        end else begin
            case (op)
                OP_ADD, OP_ADDS: begin uw = ua + ub;            sw = sa + sb;            end
                OP_SUB, OP_SUBS: begin uw = ua - ub;            sw = sa - sb;            end
                OP_ADDC:         begin uw = ua + ub + cc;       sw = sa + sb + cc;       end
                default:         begin uw = ua - ub - ONE + cc; sw = sa - sb - ONE + cc; end
            endcase
            is_sub  = (op == OP_SUB) || (op == OP_SUBS) || (op == OP_SUBC);
            e.wen   = 1'b1;
            e.carry = is_sub ? (uw >= ZERO) : (uw >= TWO_W);
            e.ovf   = (sw > SMAX) || (sw < SMIN);
            e.data  = uw[W-1:0];
            if (((op == OP_ADDS) || (op == OP_SUBS)) && e.ovf)
                e.data = (sw > SMAX) ? MAXP : MINN;
            m_carry = e.carry;
            m_ovf   = e.ovf;
        end
        exp_q.push_back(e);
    endfunction

    // Present one op from posedge+1; returns at accept edge + 1
    task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rd, input logic use_imm, input logic [15:0] imm,
                         input logic [3:0] cmp);
        logic ok;
        logic [W-1:0] bop;
        i_valid   = 1'b1;
        i_opcode  = op;
        ina       = a;
        inb       = b;
        i_regd    = rd;
        i_rega    = rd ^ 5'h1f;
        i_regb    = rd + 5'd1;
        i_use_imm = use_imm;
        i_imm     = imm;
        i_cmp_op  = cmp;
        bop = use_imm ? {{(W-16){imm[15]}}, imm} : b;
        ok  = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge i_clk);
            if (o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk1("accept_timeout", o_ready, 1'b1);
        end else begin
            chk1("unique_ack_match", o_unique_ack, 1'b1);
            chkw("sela", W'(o_sela), W'(rd ^ 5'h1f));
            @(posedge i_clk);
            model_push(op, a, bop, cmp, rd);
            #1;
        end
        i_valid = 1'b0;
    endtask

    // Scoreboard: whatever sits in S2 must match the queue head
    always @(negedge i_clk) begin
        if (!i_rst && (write_en || write_flag)) begin
            if (exp_q.size() == 0) begin
                chk1("unexpected_retire", write_en | write_flag, 1'b0);
            end else begin
                ce = exp_q[0];
                chk1("write_en", write_en, ce.wen);
                chk1("write_flag", write_flag, ce.wflag);
                chkw("write_reg", W'(write_reg), W'(ce.rd));
                if (ce.wen)   chkw("write_data", write_data, ce.data);
                if (ce.wflag) chk1("flag_cmp", flag_cmp, ce.flag);
                chk1("o_carry", o_carry, ce.carry);
                chk1("o_overflow", o_overflow, ce.ovf);
                if (i_wb_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_opcode = '0; i_rega = '0; i_regb = '0;
        i_regd = '0; i_use_imm = 1'b0; i_imm = '0; i_cmp_op = '0;
        i_unique_ack = 1'b0; ina = '0; inb = '0; i_wb_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk1("rst_write_en", write_en, 1'b0);
        chk1("rst_write_flag", write_flag, 1'b0);
        chkw("rst_write_data", write_data, '0);
        chk1("rst_carry", o_carry, 1'b0);
        chk1("rst_ovf", o_overflow, 1'b0);
        chk1("rst_ready", o_ready, 1'b1);

        // Single ADD, result two edges after accept
        @(posedge i_clk); #1;
        issue(OP_ADD, 64'd5, 64'd7, 5'd3, 1'b0, 16'h0, 4'd0);
        @(negedge i_clk); @(negedge i_clk);
        chk1("t1_wen", write_en, 1'b1);
        chkw("t1_reg", W'(write_reg), 64'd3);
        chkw("t1_data", write_data, 64'd12);
        chk1("t1_carry", o_carry, 1'b0);
        chk1("t1_wflag", write_flag, 1'b0);

        // ADD producing carry, then ADDC consuming it back-to-back
        @(posedge i_clk); #1;
        issue(OP_ADD, ALL1, 64'd1, 5'd4, 1'b0, 16'h0, 4'd0);
        issue(OP_ADDC, 64'd0, 64'd0, 5'd5, 1'b0, 16'h0, 4'd0);
        @(negedge i_clk);
        chkw("t2_data0", write_data, 64'd0);
        chk1("t2_carry0", o_carry, 1'b1);
        @(negedge i_clk);
        chkw("t2_data1", write_data, 64'd1);
        chk1("t2_carry1", o_carry, 1'b0);

        // ICMP against immediate -1
        @(posedge i_clk); #1;
        issue(OP_ICMP, 64'd0, 64'd0, 5'd7, 1'b1, 16'hFFFF, 4'd3);
        @(negedge i_clk); @(negedge i_clk);
        chk1("t3_gts", flag_cmp, 1'b1);
        chk1("t3_wflag", write_flag, 1'b1);
        chk1("t3_wen", write_en, 1'b0);
        @(posedge i_clk); #1;
        issue(OP_ICMP, 64'd0, 64'd0, 5'd7, 1'b1, 16'hFFFF, 4'd2);
        @(negedge i_clk); @(negedge i_clk);
        chk1("t3_gtu", flag_cmp, 1'b0);

        // Mixed stream checked by the scoreboard
        @(posedge i_clk); #1;
        issue(OP_SUB,  64'd3, 64'd5, 5'd10, 1'b0, 16'h0, 4'd0);
        issue(OP_SUB,  MINN, 64'd1, 5'd11, 1'b0, 16'h0, 4'd0);
        issue(OP_SUBC, 64'd10, 64'd3, 5'd12, 1'b0, 16'h0, 4'd0);
        issue(OP_SUBC, 64'd2, 64'd5, 5'd13, 1'b0, 16'h0, 4'd0);
        issue(OP_SUBC, 64'd5, 64'd2, 5'd14, 1'b0, 16'h0, 4'd0);
        issue(OP_ADD,  MAXP, 64'd1, 5'd15, 1'b0, 16'h0, 4'd0);
        issue(OP_ADDC, ALL1, ALL1, 5'd16, 1'b0, 16'h0, 4'd0);
        issue(OP_ADD,  64'd100, 64'd0, 5'd17, 1'b1, 16'hFFF6, 4'd0);
        for (int c = 0; c < 12; c++) begin
            issue(OP_ICMP, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 5'd20, 1'b0, 16'h0, 4'(c));
            issue(OP_ICMP, 64'd9, 64'd9, 5'd21, 1'b0, 16'h0, 4'(c));
        end
        repeat (4) @(posedge i_clk);
        #1;

        // Backpressure: four ADDs with writeback stalled three cycles
        i_wb_ready = 1'b0;
        fork
            begin
                for (int n = 0; n < 4; n++)
                    issue(OP_ADD, 64'(n * 10), 64'(n + 1), 5'(n + 24), 1'b0, 16'h0, 4'd0);
            end
            begin
                repeat (2) @(posedge i_clk);
                @(negedge i_clk);
                chk1("t4_ready_full", o_ready, 1'b0);
                @(posedge i_clk);
                #1 i_wb_ready = 1'b1;
            end
        join
        repeat (4) @(posedge i_clk);
        #1;
        chkw("t4_drained", 64'(exp_q.size()), 64'd0);

        // Upstream claim and unmatched opcode are ignored
        i_valid = 1'b1; i_opcode = OP_SUB; i_unique_ack = 1'b1;
        @(negedge i_clk);
        chk1("t5_uack_claimed", o_unique_ack, 1'b0);
        i_unique_ack = 1'b0; i_opcode = 6'd0;
        @(negedge i_clk);
        chk1("t5_uack_nomatch", o_unique_ack, 1'b0);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;

        // Reset with two ops in flight
        i_wb_ready = 1'b0;
        issue(OP_ADD, ALL1, 64'd1, 5'd8, 1'b0, 16'h0, 4'd0);
        issue(OP_ADD, 64'd1, 64'd1, 5'd9, 1'b0, 16'h0, 4'd0);
        chk1("t5_carry_pre_rst", o_carry, 1'b1);
        i_rst = 1'b1;
        @(posedge i_clk);
        exp_q.delete();
        m_carry = 1'b0;
        m_ovf   = 1'b0;
        #1 i_rst = 1'b0;
        i_wb_ready = 1'b1;
        @(negedge i_clk);
        chk1("t5_rst_wen", write_en, 1'b0);
        chk1("t5_rst_wflag", write_flag, 1'b0);
        chk1("t5_rst_carry", o_carry, 1'b0);
        chk1("t5_rst_ready", o_ready, 1'b1);
        repeat (5) @(posedge i_clk);
        #1;

`ifdef PU_ADD_CMP_SAT_EN
        issue(OP_ADDS, MAXP, 64'd1, 5'd2, 1'b0, 16'h0, 4'd0);
        @(negedge i_clk); @(negedge i_clk);
        chkw("t6_adds_data", write_data, MAXP);
        chk1("t6_adds_ovf", o_overflow, 1'b1);
        @(posedge i_clk); #1;
        issue(OP_SUBS, MINN, 64'd1, 5'd2, 1'b0, 16'h0, 4'd0);
        @(negedge i_clk); @(negedge i_clk);
        chkw("t6_subs_data", write_data, MINN);
        @(posedge i_clk); #1;
`else
        i_valid = 1'b1; i_opcode = OP_ADDS;
        @(negedge i_clk);
        chk1("t6_adds_uack", o_unique_ack, 1'b0);
        i_opcode = OP_SUBS;
        @(negedge i_clk);
        chk1("t6_subs_uack", o_unique_ack, 1'b0);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
`endif
        repeat (5) @(posedge i_clk);
        #1;
        chkw("final_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
